// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the CDB arbiter slice.
package cdb_arbiter_pkg;

  // ROB id width seen across the core; the arbiter parameter must match it
  localparam int CFG_ROB_SIZE_BIT = 4;

  // Producer indices on the common data bus
  localparam int CDB_SRC_ALU = 0;
  localparam int CDB_SRC_LSB = 1;
  localparam int CDB_SRC_BRU = 2;
  localparam int CDB_SRC_BIT = 2;
  localparam int CDB_N_SRC   = 3;
  localparam int CDB_DATA_W  = 32;

  // Result of one round-robin scan
  typedef struct packed {
    logic                   vld;
    logic [CDB_SRC_BIT-1:0] idx;
  } cdb_gnt_t;

  // Round-robin successor of a granted source, wrapping at n
  function automatic logic [CDB_SRC_BIT-1:0] rr_next(input logic [CDB_SRC_BIT-1:0] g,
                                                     input int n);
    return (int'(g) == n - 1) ? '0 : g + CDB_SRC_BIT'(1);
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Small per-producer result FIFO with push, pop, flush and registered count.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] r_mem;
  logic [AW-1:0]               r_wr_ptr;
  logic [AW-1:0]               r_rd_ptr;
  logic [CW-1:0]               r_count;

  // Storage: written on accepted push only; contents need no reset
  always_ff @(posedge i_clk) begin
    if (i_en && i_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers and occupancy; DEPTH is a power of 2 so pointers wrap naturally
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_en) begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(i_push) - CW'(i_pop);
      end
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB broadcast among N_SRC producers.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC        = CDB_N_SRC,
  parameter int FIFO_DEPTH   = 2,
  parameter int ROB_SIZE_BIT = CFG_ROB_SIZE_BIT
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          rob_clear,
  input  logic [N_SRC-1:0]              src_valid,
  input  logic [N_SRC*32-1:0]           src_value,
  input  logic [N_SRC*ROB_SIZE_BIT-1:0] src_rob_id,
  output logic [N_SRC-1:0]              src_ready,
  output logic                          cdb_valid,
  output logic [31:0]                   cdb_value,
  output logic [ROB_SIZE_BIT-1:0]       cdb_rob_id,
  output logic [CDB_SRC_BIT-1:0]        cdb_src,
  output logic                          arb_idle
);

  localparam int EW = CDB_DATA_W + ROB_SIZE_BIT;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [N_SRC-1:0][EW-1:0]          w_din;
  logic [N_SRC-1:0][EW-1:0]          w_head;
  logic [N_SRC-1:0][CW-1:0]          w_count;
  logic [N_SRC-1:0]                  w_push;
  logic [N_SRC-1:0]                  w_pop;
  logic [N_SRC-1:0]                  w_nonempty;
  logic [N_SRC-1:0][CDB_SRC_BIT-1:0] w_scan_idx;
  cdb_gnt_t                          w_gnt;
  logic [EW-1:0]                     w_gnt_data;

  logic                              r_cdb_valid;
  logic [31:0]                       r_cdb_value;
  logic [ROB_SIZE_BIT-1:0]           r_cdb_rob_id;
  logic [CDB_SRC_BIT-1:0]            r_cdb_src;
  logic [CDB_SRC_BIT-1:0]            r_rr_ptr;

  // A flush cycle neither accepts nor pops; the FIFOs are cleared instead.
  // Ready comes from the registered count only, so a full FIFO popping now stays not-ready.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign w_din[i]      = {src_value[32*i +: 32], src_rob_id[ROB_SIZE_BIT*i +: ROB_SIZE_BIT]};
    assign src_ready[i]  = (w_count[i] != CW'(FIFO_DEPTH));
    assign w_nonempty[i] = (w_count[i] != '0);
    assign w_push[i]     = rdy_in & ~rob_clear & src_valid[i] & src_ready[i];
    assign w_pop[i]      = rdy_in & ~rob_clear & w_gnt.vld & (w_gnt.idx == CDB_SRC_BIT'(i));
    assign w_scan_idx[i] = CDB_SRC_BIT'((int'(r_rr_ptr) + i) % N_SRC);

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .i_clk   (clk_in),
      .i_rst_n (rst_in),
      .i_en    (rdy_in),
      .i_push  (w_push[i]),
      .i_pop   (w_pop[i]),
      .i_flush (rob_clear),
      .i_din   (w_din[i]),
      .o_head  (w_head[i]),
      .o_count (w_count[i])
    );
  end

  // Scan heads starting at rr_ptr and grant the first non-empty one
  always_comb begin
    w_gnt      = '0;
    w_gnt_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!w_gnt.vld && w_nonempty[w_scan_idx[k]]) begin
        w_gnt.vld  = 1'b1;
        w_gnt.idx  = w_scan_idx[k];
        w_gnt_data = w_head[w_scan_idx[k]];
      end
    end
  end

  // Registered broadcast and round-robin pointer; data regs hold when nothing is granted
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_cdb_valid  <= 1'b0;
      r_cdb_value  <= '0;
      r_cdb_rob_id <= '0;
      r_cdb_src    <= '0;
      r_rr_ptr     <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        r_cdb_valid <= 1'b0;
        r_rr_ptr    <= '0;
      end else if (w_gnt.vld) begin
        r_cdb_valid  <= 1'b1;
        r_cdb_value  <= w_gnt_data[EW-1 -: CDB_DATA_W];
        r_cdb_rob_id <= w_gnt_data[ROB_SIZE_BIT-1:0];
        r_cdb_src    <= w_gnt.idx;
        r_rr_ptr     <= rr_next(w_gnt.idx, N_SRC);
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  assign cdb_valid  = r_cdb_valid;
  assign cdb_value  = r_cdb_value;
  assign cdb_rob_id = r_cdb_rob_id;
  assign cdb_src    = r_cdb_src;
  assign arb_idle   = ~r_cdb_valid & ~(|w_nonempty);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        rob_clear;
  logic [2:0]  src_valid;
  logic [95:0] src_value;
  logic [11:0] src_rob_id;
  logic [2:0]  src_ready;
  logic        cdb_valid;
  logic [31:0] cdb_value;
  logic [3:0]  cdb_rob_id;
  logic [1:0]  cdb_src;
  logic        arb_idle;

  int checks   = 0;
  int failures = 0;

  cdb_arbiter #(.N_SRC(3), .FIFO_DEPTH(2), .ROB_SIZE_BIT(4)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .rob_clear  (rob_clear),
    .src_valid  (src_valid),
    .src_value  (src_value),
    .src_rob_id (src_rob_id),
    .src_ready  (src_ready),
    .cdb_valid  (cdb_valid),
    .cdb_value  (cdb_value),
    .cdb_rob_id (cdb_rob_id),
    .cdb_src    (cdb_src),
    .arb_idle   (arb_idle)
  );

  always #5 clk_in = ~clk_in;

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge
  task automatic tick;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic drive(input int i, input logic v, input logic [31:0] val, input logic [3:0] rob);
    src_valid[i]         = v;
    src_value[32*i +: 32] = val;
    src_rob_id[4*i +: 4] = rob;
  endtask

  task automatic do_reset;
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0;
    src_valid = '0; src_value = '0; src_rob_id = '0;
    tick; tick;
    rst_in = 1'b1;
  endtask

  task automatic test_reset;
    src_valid = 3'b111; src_value = '1; src_rob_id = '1;
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b1;
    tick; tick;
    rst_in = 1'b1; rob_clear = 1'b0; src_valid = '0;
    checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", cdb_valid); end
    checks++; if (cdb_value !== 32'h0) begin failures++; $display("FAIL reset_value got=%h exp=0", cdb_value); end
    checks++; if (cdb_rob_id !== 4'd0) begin failures++; $display("FAIL reset_rob got=%0d exp=0", cdb_rob_id); end
    checks++; if (cdb_src !== 2'd0) begin failures++; $display("FAIL reset_src got=%0d exp=0", cdb_src); end
    checks++; if (src_ready !== 3'b111) begin failures++; $display("FAIL reset_ready got=%b exp=111", src_ready); end
    checks++; if (arb_idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%0b exp=1", arb_idle); end
  endtask

  task automatic test_single;
    do_reset;
    drive(0, 1'b1, 32'hDEADBEEF, 4'd5);
    tick;
    drive(0, 1'b0, 32'h0, 4'd0);
    checks++; if (cdb_valid !== 1'b0 || arb_idle !== 1'b0) begin
      failures++; $display("FAIL single_lat1 valid=%0b idle=%0b exp valid=0 idle=0", cdb_valid, arb_idle); end
    tick;
    checks++; if (cdb_valid !== 1'b1 || cdb_value !== 32'hDEADBEEF || cdb_rob_id !== 4'd5 || cdb_src !== 2'd0) begin
      failures++; $display("FAIL single_bcast got v=%0b %h rob=%0d src=%0d exp v=1 deadbeef rob=5 src=0",
                           cdb_valid, cdb_value, cdb_rob_id, cdb_src); end
    tick;
    checks++; if (cdb_valid !== 1'b0 || arb_idle !== 1'b1) begin
      failures++; $display("FAIL single_idle valid=%0b idle=%0b exp valid=0 idle=1", cdb_valid, arb_idle); end
  endtask

  // All producers offer continuously; each source's values carry its own sequence number
  task automatic test_round_robin;
    int seq [3];
    int expk[3];
    logic [2:0] take;
    logic [2:0] exp_rdy;
    int g;
    do_reset;
    for (int i = 0; i < 3; i++) begin seq[i] = 0; expk[i] = 0; end
    for (int c = 0; c < 14; c++) begin
      for (int i = 0; i < 3; i++) drive(i, 1'b1, {8'(i), 24'(seq[i])}, 4'(seq[i]));
      exp_rdy = (c < 2) ? 3'b111 : (3'b001 << ((c - 2) % 3));
      checks++; if (src_ready !== exp_rdy) begin
        failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, src_ready, exp_rdy); end
      if (c >= 2) begin
        g = (c - 2) % 3;
        checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'(g) || cdb_value !== {8'(g), 24'(expk[g])}) begin
          failures++; $display("FAIL rr_grant c=%0d got v=%0b src=%0d val=%h exp src=%0d val=%h",
                               c, cdb_valid, cdb_src, cdb_value, g, {8'(g), 24'(expk[g])}); end
        expk[g]++;
      end else if (c == 1) begin
        checks++; if (cdb_valid !== 1'b0) begin failures++; $display("FAIL rr_early got=%0b exp=0", cdb_valid); end
      end
      take = src_ready;
      tick;
      for (int i = 0; i < 3; i++) if (take[i]) seq[i]++;
    end
    src_valid = '0;
  endtask

  // LSB issues three back-to-back results while ALU and BRU heads compete for the bus
  task automatic test_backpressure;
    int exp_rob[7] = '{1, 3, 6, 2, 4, 7, 5};
    int exp_src[7] = '{0, 1, 2, 0, 1, 2, 1};
    do_reset;
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: begin drive(0, 1'b1, 32'h101, 4'd1); drive(1, 1'b1, 32'h103, 4'd3); drive(2, 1'b1, 32'h106, 4'd6); end
        1: begin drive(0, 1'b1, 32'h102, 4'd2); drive(1, 1'b1, 32'h104, 4'd4); drive(2, 1'b1, 32'h107, 4'd7); end
        2: begin drive(0, 1'b0, 32'h0, 4'd0);   drive(1, 1'b1, 32'h105, 4'd5); drive(2, 1'b0, 32'h0, 4'd0); end
        4: drive(1, 1'b0, 32'h0, 4'd0);
        default: ;
      endcase
      if (c == 2) begin
        checks++; if (src_ready[1] !== 1'b0) begin failures++; $display("FAIL bp_full got=%0b exp=0", src_ready[1]); end
      end
      if (c == 3) begin
        checks++; if (src_ready[1] !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%0b exp=1", src_ready[1]); end
      end
      if (c >= 2 && c <= 8) begin
        checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'(exp_src[c-2]) || cdb_rob_id !== 4'(exp_rob[c-2]) ||
                      cdb_value !== 32'(32'h100 + exp_rob[c-2])) begin
          failures++; $display("FAIL bp_order c=%0d got v=%0b src=%0d rob=%0d val=%h exp src=%0d rob=%0d",
                               c, cdb_valid, cdb_src, cdb_rob_id, cdb_value, exp_src[c-2], exp_rob[c-2]); end
      end
      if (c == 9) begin
        checks++; if (cdb_valid !== 1'b0 || arb_idle !== 1'b1) begin
          failures++; $display("FAIL bp_drain valid=%0b idle=%0b exp 0/1", cdb_valid, arb_idle); end
      end
      tick;
    end
  endtask

  task automatic fill_two_rounds;
    drive(0, 1'b1, 32'h201, 4'd1); drive(1, 1'b1, 32'h202, 4'd2); drive(2, 1'b1, 32'h203, 4'd3);
    tick;
    drive(0, 1'b1, 32'h204, 4'd4); drive(1, 1'b1, 32'h205, 4'd5); drive(2, 1'b1, 32'h206, 4'd6);
    tick;
  endtask

  task automatic test_flush;
    do_reset;
    fill_two_rounds;
    src_valid = '0;
    drive(0, 1'b1, 32'h207, 4'd7);
    rob_clear = 1'b1;
    checks++; if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'd1) begin
      failures++; $display("FAIL flush_cycle_bcast v=%0b rob=%0d exp v=1 rob=1", cdb_valid, cdb_rob_id); end
    tick;
    rob_clear = 1'b0; src_valid = '0;
    checks++; if (cdb_valid !== 1'b0 || src_ready !== 3'b111 || arb_idle !== 1'b1) begin
      failures++; $display("FAIL flush_after v=%0b rdy=%b idle=%0b exp 0/111/1", cdb_valid, src_ready, arb_idle); end
    for (int c = 0; c < 3; c++) begin
      tick;
      checks++; if (cdb_valid !== 1'b0) begin
        failures++; $display("FAIL flush_leak c=%0d got v=1 rob=%0d exp v=0", c, cdb_rob_id); end
    end
    drive(0, 1'b1, 32'h208, 4'd8); drive(1, 1'b1, 32'h209, 4'd9);
    tick;
    src_valid = '0;
    tick;
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_rob_id !== 4'd8) begin
      failures++; $display("FAIL flush_rr0 got v=%0b src=%0d rob=%0d exp 1/0/8", cdb_valid, cdb_src, cdb_rob_id); end
    tick;
    checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_rob_id !== 4'd9) begin
      failures++; $display("FAIL flush_next got v=%0b src=%0d rob=%0d exp 1/1/9", cdb_valid, cdb_src, cdb_rob_id); end
    tick;
  endtask

  task automatic test_pause;
    int exp_rob[5] = '{2, 3, 4, 5, 6};
    int exp_src[5] = '{1, 2, 0, 1, 2};
    do_reset;
    fill_two_rounds;
    rdy_in = 1'b0;
    drive(0, 1'b1, 32'h207, 4'd7); drive(1, 1'b1, 32'h208, 4'd8); drive(2, 1'b1, 32'h209, 4'd9);
    for (int p = 0; p < 4; p++) begin
      checks++; if (cdb_valid !== 1'b1 || cdb_rob_id !== 4'd1 || cdb_src !== 2'd0 || src_ready !== 3'b001) begin
        failures++; $display("FAIL pause_hold p=%0d got v=%0b rob=%0d src=%0d rdy=%b exp 1/1/0/001",
                             p, cdb_valid, cdb_rob_id, cdb_src, src_ready); end
      if (p < 3) tick;
    end
    rdy_in = 1'b1; src_valid = '0;
    for (int n = 0; n < 5; n++) begin
      tick;
      checks++; if (cdb_valid !== 1'b1 || cdb_src !== 2'(exp_src[n]) || cdb_rob_id !== 4'(exp_rob[n])) begin
        failures++; $display("FAIL pause_resume n=%0d got v=%0b src=%0d rob=%0d exp src=%0d rob=%0d",
                             n, cdb_valid, cdb_src, cdb_rob_id, exp_src[n], exp_rob[n]); end
    end
    tick;
    checks++; if (cdb_valid !== 1'b0 || arb_idle !== 1'b1) begin
      failures++; $display("FAIL pause_drain v=%0b idle=%0b exp 0/1", cdb_valid, arb_idle); end
  endtask

  task automatic test_reset_in_pause;
    do_reset;
    fill_two_rounds;
    rdy_in = 1'b0; rst_in = 1'b0;
    tick;
    checks++; if (cdb_valid !== 1'b0 || cdb_value !== 32'h0 || cdb_rob_id !== 4'd0 || cdb_src !== 2'd0) begin
      failures++; $display("FAIL rstpause_cdb got v=%0b val=%h rob=%0d src=%0d exp all 0",
                           cdb_valid, cdb_value, cdb_rob_id, cdb_src); end
    checks++; if (src_ready !== 3'b111 || arb_idle !== 1'b1) begin
      failures++; $display("FAIL rstpause_ready rdy=%b idle=%0b exp 111/1", src_ready, arb_idle); end
    rst_in = 1'b1; rdy_in = 1'b1; src_valid = '0;
    tick; tick;
    checks++; if (cdb_valid !== 1'b0 || arb_idle !== 1'b1) begin
      failures++; $display("FAIL rstpause_empty v=%0b idle=%0b exp 0/1", cdb_valid, arb_idle); end
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; rob_clear = 1'b0;
    src_valid = '0; src_value = '0; src_rob_id = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_backpressure;
    test_flush;
    test_pause;
    test_reset_in_pause;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
